// File: rtl/gDefine.sv
// Shared IO-interconnect types: data word, burst length and the read-arbiter FSM state.
package gDefine;

  localparam int DWIDTH = 32;

  typedef logic [DWIDTH-1:0] Word_t;
  typedef logic [11:0]       IoLen_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    BURST
  } IoArbState_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req searching upward from ptr, wrapping mod N.
module rr_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 found,
  output logic [$clog2(N)-1:0] index
);

  localparam int IW = $clog2(N);

  always_comb begin
    int             j;
    logic [IW-1:0]  jj;
    // NOTE: every output gets a default before the loop, so no path leaves it unassigned and no latch is inferred.
    found = 1'b0;
    index = '0;
    j     = 0;
    jj    = '0;
    // Walk from the farthest offset back to ptr so the nearest request wins last.
    for (int i = N - 1; i >= 0; i--) begin
      j  = (int'(ptr) + i) % N;
      jj = j[IW-1:0];
      if (req[jj]) begin
        found = 1'b1;
        index = jj;
      end
    end
  end

endmodule

// File: rtl/io_rd_arbiter.sv
// Round-robin owner of the single IO read channel; one burst outstanding, beats steered to the owner.
// Optional burst watchdog enabled by defining IORD_ARB_TIMEOUT_EN.
module io_rd_arbiter
  import gDefine::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NUM_REQ-1:0] req_valid,
  input  Word_t              req_addr [NUM_REQ],
  input  IoLen_t             req_len  [NUM_REQ],
  output logic [NUM_REQ-1:0] req_ack,
  output logic [NUM_REQ-1:0] rsp_valid,
  output logic [NUM_REQ-1:0] rsp_eof,
  output Word_t              rsp_data,
  output logic               rd_req,
  output Word_t              rd_addr,
  output IoLen_t             rd_len,
  input  Word_t              rd_data,
  input  logic               rd_valid,
  input  logic               rd_eof,
  output logic               busy,
  output logic [NUM_REQ-1:0] timeout
);

  localparam int IW = $clog2(NUM_REQ);
  typedef logic [IW-1:0] idx_t;

  if (NUM_REQ < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("io_rd_arbiter: NUM_REQ must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  IoArbState_t state;
  idx_t        owner;
  idx_t        rr_ptr;
  logic        pick_found;
  idx_t        pick_idx;
  logic        wd_fire;

  function automatic idx_t next_idx(input idx_t i);
    return (i == idx_t'(NUM_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .found (pick_found),
    .index (pick_idx)
  );

`ifdef IORD_ARB_TIMEOUT_EN
  localparam int TO_W = ($clog2(TIMEOUT_CYCLES + 1) > 10) ? $clog2(TIMEOUT_CYCLES + 1) : 10;
  logic [TO_W-1:0] wd_cnt;

  // Held at zero outside BURST, so it is already clear on entry.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                         wd_cnt <= '0;
    else if (state != BURST || rd_valid) wd_cnt <= '0;
    else                               wd_cnt <= wd_cnt + 1'b1;
  end

  assign wd_fire = (state == BURST) && !rd_valid && (wd_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign wd_fire = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      req_ack   <= '0;
      rsp_valid <= '0;
      rsp_eof   <= '0;
      rsp_data  <= '0;
      rd_req    <= 1'b0;
      rd_addr   <= '0;
      rd_len    <= '0;
      busy      <= 1'b0;
      timeout   <= '0;
    end else begin
      req_ack   <= '0;
      rd_req    <= 1'b0;
      rsp_valid <= '0;
      rsp_eof   <= '0;
      timeout   <= '0;
      unique case (state)
        IDLE: begin
          // Pulses are launched here so they are visible during the ISSUE cycle.
          if (pick_found) begin
            owner             <= pick_idx;
            rd_addr           <= req_addr[pick_idx];
            rd_len            <= req_len[pick_idx];
            req_ack[pick_idx] <= 1'b1;
            rd_req            <= (req_len[pick_idx] != '0);
            busy              <= 1'b1;
            state             <= ISSUE;
          end
        end
        ISSUE: begin
          if (rd_len != '0) begin
            state <= BURST;
          end else begin
            rr_ptr <= next_idx(owner);
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        BURST: begin
          if (rd_valid) begin
            rsp_valid[owner] <= 1'b1;
            rsp_eof[owner]   <= rd_eof;
            rsp_data         <= rd_data;
            if (rd_eof) begin
              rr_ptr <= next_idx(owner);
              busy   <= 1'b0;
              state  <= IDLE;
            end
          end else if (wd_fire) begin
            timeout[owner] <= 1'b1;
            rr_ptr         <= next_idx(owner);
            busy           <= 1'b0;
            state          <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
